// File: rtl/cmp_sweep_checker_pkg.sv
// Shared definitions for the comparator sweep checker: the 2-bit comparator
// result codes and the sweep controller state encoding.
package cmp_pkg;

    localparam logic [1:0] CMP_INV = 2'b00;
    localparam logic [1:0] CMP_GT  = 2'b01;
    localparam logic [1:0] CMP_LT  = 2'b10;
    localparam logic [1:0] CMP_EQ  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cmp_sweep_checker_if.sv
// Connection between the sweep checker (master, drives operands) and the
// comparator under test (slave, returns the 2-bit result code).
interface cmp_sweep_checker_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [1:0]       cmp_in;

    modport master (output a_out, output b_out, input cmp_in);
    modport slave  (input a_out, input b_out, output cmp_in);
endinterface

// File: rtl/cmp_sweep_checker_expect.sv
// Combinational golden comparator: unsigned compare of a and b, returned in
// the same 2-bit code the comparator under test is expected to produce.
module cmp_expect
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [1:0]       o_code
);

    // NOTE: a combinational block assigns every output first, so no path
    // through it can leave a value unassigned and infer a latch.
    always_comb begin
        o_code = CMP_EQ;
        if (i_a > i_b) begin
            o_code = CMP_GT;
        end else if (i_a < i_b) begin
            o_code = CMP_LT;
        end
    end

endmodule

// File: rtl/cmp_sweep_checker.sv
// Sweeps every (a, b) operand pair onto a comparator under test, samples its
// code after SETTLE idle cycles and records the error count and first failure.
module cmp_sweep_checker
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    cmp_sweep_checker_if.master  cmp_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [1:0]           fail_code,
    output logic                 fail_valid
);

    localparam int               ERR_W     = 2 * WIDTH + 1;
    localparam int               CNT_W     = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam state_t           ST_AFTER_LOAD = (SETTLE == 0) ? CHECK : WAIT;

    state_t             r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_a,      w_a_nxt;
    logic [WIDTH-1:0]   r_b,      w_b_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [ERR_W-1:0]   r_err,    w_err_nxt;
    logic [WIDTH-1:0]   r_fail_a, w_fail_a_nxt;
    logic [WIDTH-1:0]   r_fail_b, w_fail_b_nxt;
    logic [1:0]         r_fail_c, w_fail_c_nxt;
    logic               r_fail_v, w_fail_v_nxt;
    logic [1:0]         w_expect;

    cmp_expect #(.WIDTH(WIDTH)) u_expect (
        .i_a    (r_a),
        .i_b    (r_b),
        .o_code (w_expect)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_fail_a_nxt = r_fail_a;
        w_fail_b_nxt = r_fail_b;
        w_fail_c_nxt = r_fail_c;
        w_fail_v_nxt = r_fail_v;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_a_nxt      = '0;
                    w_b_nxt      = '0;
                    w_cnt_nxt    = SETTLE_LD;
                    w_err_nxt    = '0;
                    w_fail_a_nxt = '0;
                    w_fail_b_nxt = '0;
                    w_fail_c_nxt = CMP_INV;
                    w_fail_v_nxt = 1'b0;
                    w_state_nxt  = ST_AFTER_LOAD;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                // An invalid 00 code never equals an expected code, so it counts as a mismatch.
                if (cmp_bus.cmp_in != w_expect) begin
                    w_err_nxt = r_err + ERR_W'(1);
                    if (!r_fail_v) begin
                        w_fail_a_nxt = r_a;
                        w_fail_b_nxt = r_b;
                        w_fail_c_nxt = cmp_bus.cmp_in;
                        w_fail_v_nxt = 1'b1;
                    end
                end
                if (r_a == ALL_ONES && r_b == ALL_ONES) begin
                    w_state_nxt = DONE;
                end else begin
                    w_b_nxt = r_b + WIDTH'(1);
                    if (r_b == ALL_ONES) begin
                        w_a_nxt = r_a + WIDTH'(1);
                    end
                    w_cnt_nxt   = SETTLE_LD;
                    w_state_nxt = ST_AFTER_LOAD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_fail_a <= '0;
            r_fail_b <= '0;
            r_fail_c <= CMP_INV;
            r_fail_v <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_fail_a <= w_fail_a_nxt;
            r_fail_b <= w_fail_b_nxt;
            r_fail_c <= w_fail_c_nxt;
            r_fail_v <= w_fail_v_nxt;
        end
    end

    assign cmp_bus.a_out = r_a;
    assign cmp_bus.b_out = r_b;
    assign busy          = (r_state == WAIT) || (r_state == CHECK);
    assign done          = (r_state == DONE);
    assign pass          = done && (r_err == '0);
    assign err_count     = r_err;
    assign fail_a        = r_fail_a;
    assign fail_b        = r_fail_b;
    assign fail_code     = r_fail_c;
    assign fail_valid    = r_fail_v;

endmodule
